// File: rtl/ldlt_stream_checker.sv
// Self-checking comparator for the packed lower-triangular L stream of the LDLT solver.
// Counts failing elements, records the first failing index, and flags stalls and surplus data.
module ldlt_stream_checker #(
    parameter int unsigned DATA_LEN  = 32,
    parameter int unsigned FRACTION  = 16,
    parameter int unsigned NODE_NUM  = 1,
    parameter int unsigned TOL_RATIO = 5,
    parameter int unsigned TIMEOUT   = 65535,
    localparam int unsigned L_SIZE   = 6 * NODE_NUM * (6 * NODE_NUM + 1) / 2,
    localparam int unsigned CNT_W    = $clog2(L_SIZE + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_mode,
    input  logic                i_valid,
    input  logic [DATA_LEN-1:0] i_data,
    input  logic [DATA_LEN-1:0] i_gold,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic [CNT_W-1:0]    o_err_cnt,
    output logic [CNT_W-1:0]    o_first_err_idx,
    output logic                o_first_err_vld,
    output logic                o_timeout,
    output logic                o_overrun
);

    localparam int unsigned EXT_W  = DATA_LEN + 1;
    localparam int unsigned PROD_W = DATA_LEN + 1 + $clog2(TOL_RATIO + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    // The comparison is scale-free, so FRACTION only needs to be sane.
    if (FRACTION >= DATA_LEN) begin : g_bad_fraction
        $error("FRACTION must be smaller than DATA_LEN");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic               r_mode;
    logic [CNT_W-1:0]   r_idx;
    logic [IDLE_W-1:0]  r_idle;
    logic               r_s1_vld;
    logic               r_s1_fail;
    logic [CNT_W-1:0]   r_s1_idx;
    logic               r_s1_last;
    logic               r_s2_last;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [CNT_W-1:0]   r_first_idx;
    logic               r_first_vld;
    logic               r_timeout;
    logic               r_overrun;

    logic               w_active;
    logic               w_accept;
    logic               w_last;
    logic               w_idle_hit;
    logic               w_surplus;
    logic [EXT_W-1:0]   w_gold_ext;
    logic [EXT_W-1:0]   w_data_ext;
    logic [EXT_W-1:0]   w_diff;
    logic [EXT_W-1:0]   w_abs_diff;
    logic [EXT_W-1:0]   w_abs_data;
    logic [PROD_W-1:0]  w_prod;
    logic               w_fail;

    assign w_active   = (r_state == S_WAIT) || (r_state == S_RUN);
    assign w_accept   = w_active && i_valid && !i_start;
    assign w_last     = w_accept && (r_idx == CNT_W'(L_SIZE - 1));
    assign w_idle_hit = w_active && !i_valid && !i_start && (r_idle == IDLE_W'(TIMEOUT - 1));
    assign w_surplus  = ((r_state == S_DRAIN) || (r_state == S_DONE)) && i_valid && !i_start;

    // Magnitudes are formed one bit wider so the most negative input cannot wrap.
    assign w_gold_ext = {i_gold[DATA_LEN-1], i_gold};
    assign w_data_ext = {i_data[DATA_LEN-1], i_data};
    assign w_diff     = w_gold_ext - w_data_ext;
    assign w_abs_diff = w_diff[EXT_W-1] ? (~w_diff + EXT_W'(1)) : w_diff;
    assign w_abs_data = w_data_ext[EXT_W-1] ? (~w_data_ext + EXT_W'(1)) : w_data_ext;
    assign w_prod     = PROD_W'(w_abs_diff) * PROD_W'(TOL_RATIO);
    assign w_fail     = (w_diff != '0) && (!r_mode || (PROD_W'(w_abs_data) < w_prod));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DRAIN covers the two pipeline edges between the last accept and the verdict.
    always_comb begin
        w_next = r_state;
        if (i_start) begin
            w_next = S_WAIT;
        end else begin
            case (r_state)
                S_WAIT, S_RUN: begin
                    if (w_last) begin
                        w_next = S_DRAIN;
                    end else if (w_accept) begin
                        w_next = S_RUN;
                    end else if (w_idle_hit) begin
                        w_next = S_DONE;
                    end
                end
                S_DRAIN: begin
                    if (r_s2_last) begin
                        w_next = S_DONE;
                    end
                end
                default: begin
                    w_next = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= 1'b0;
            r_idx       <= '0;
            r_idle      <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_fail   <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_last   <= 1'b0;
            r_s2_last   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
            r_timeout   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_busy <= (w_next == S_WAIT) || (w_next == S_RUN) || (w_next == S_DRAIN);
            r_done <= (w_next == S_DONE);
            if (i_start) begin
                r_mode      <= i_mode;
                r_idx       <= '0;
                r_idle      <= '0;
                r_s1_vld    <= 1'b0;
                r_s1_fail   <= 1'b0;
                r_s1_idx    <= '0;
                r_s1_last   <= 1'b0;
                r_s2_last   <= 1'b0;
                r_pass      <= 1'b0;
                r_err_cnt   <= '0;
                r_first_idx <= '0;
                r_first_vld <= 1'b0;
                r_timeout   <= 1'b0;
                r_overrun   <= 1'b0;
            end else begin
                r_s1_vld  <= w_accept;
                r_s1_fail <= w_fail;
                r_s1_idx  <= r_idx;
                r_s1_last <= w_last;
                r_s2_last <= r_s1_last;

                if (w_accept) begin
                    r_idx  <= r_idx + CNT_W'(1);
                    r_idle <= '0;
                end else if (w_active && !w_idle_hit) begin
                    r_idle <= r_idle + IDLE_W'(1);
                end

                if (r_s1_vld && r_s1_fail) begin
                    if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + CNT_W'(1);
                    end
                    if (!r_first_vld) begin
                        r_first_idx <= r_s1_idx;
                        r_first_vld <= 1'b1;
                    end
                end

                if (w_idle_hit) begin
                    r_timeout <= 1'b1;
                end
                if (w_surplus) begin
                    r_overrun <= 1'b1;
                end

                // Verdict is taken once the last flag has reached the counters.
                if ((r_state == S_DRAIN) && r_s2_last) begin
                    r_pass <= (r_err_cnt == '0) && !r_timeout && !r_overrun && !w_surplus;
                end else if (w_surplus) begin
                    r_pass <= 1'b0;
                end
            end
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pass          = r_pass;
    assign o_err_cnt       = r_err_cnt;
    assign o_first_err_idx = r_first_idx;
    assign o_first_err_vld = r_first_vld;
    assign o_timeout       = r_timeout;
    assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_ldlt_stream_checker.sv
// Scoreboard bench for ldlt_stream_checker: NODE_NUM=1 (21 elements), TOL_RATIO=5, TIMEOUT=16.
module tb_ldlt_stream_checker;

    localparam int L = 21;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_mode = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic [31:0] i_gold = '0;
    logic        o_busy, o_done, o_pass, o_first_err_vld, o_timeout, o_overrun;
    logic [4:0]  o_err_cnt, o_first_err_idx;

    typedef struct {
        int err;
        int first;
        bit fvld;
        bit pass;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          last_err = 0;
    logic [31:0] s_data[L];
    logic [31:0] s_gold[L];

    ldlt_stream_checker #(
        .DATA_LEN(32), .FRACTION(16), .NODE_NUM(1), .TOL_RATIO(5), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
        .i_valid(i_valid), .i_data(i_data), .i_gold(i_gold),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
        .o_err_cnt(o_err_cnt), .o_first_err_idx(o_first_err_idx),
        .o_first_err_vld(o_first_err_vld), .o_timeout(o_timeout), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_fail(input bit m, input logic [31:0] d, input logic [31:0] g);
        longint df, adf, ad;
        df  = longint'($signed(g)) - longint'($signed(d));
        adf = (df < 0) ? -df : df;
        ad  = ($signed(d) < 0) ? -longint'($signed(d)) : longint'($signed(d));
        return m ? ((df != 0) && (ad < 5 * adf)) : (df != 0);
    endfunction

    task automatic fill_clean();
        for (int i = 0; i < L; i++) begin
            s_data[i] = $urandom;
            s_gold[i] = s_data[i];
        end
    endtask

    task automatic run_stream(input bit m, input bit do_start, input int max_gap);
        exp_t e;
        e.err = 0; e.first = 0; e.fvld = 1'b0;
        for (int i = 0; i < L; i++) begin
            if (model_fail(m, s_data[i], s_gold[i])) begin
                if (!e.fvld) begin
                    e.fvld  = 1'b1;
                    e.first = i;
                end
                e.err++;
            end
        end
        e.pass = (e.err == 0);
        sb.push_back(e);
        if (do_start) begin
            i_start = 1'b1; i_mode = m;
            cyc();
            i_start = 1'b0;
        end
        for (int i = 0; i < L; i++) begin
            i_valid = 1'b1; i_data = s_data[i]; i_gold = s_gold[i];
            cyc();
            i_valid = 1'b0;
            if (max_gap > 0 && i != L - 1) begin
                repeat ($urandom_range(1, max_gap)) cyc();
            end
        end
    endtask

    task automatic wait_done(input string name);
        int   n = 0;
        exp_t e;
        while (o_done !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        total++;
        if (o_done !== 1'b1) begin
            bad++;
            $display("FAIL %s done_wait got=%b exp=1 after %0d cycles", name, o_done, n);
        end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard got=empty exp=entry", name);
        end else begin
            e = sb.pop_front();
            last_err = e.err;
            if (o_err_cnt !== 5'(e.err)) begin
                bad++;
                $display("FAIL %s err_cnt got=%0d exp=%0d", name, o_err_cnt, e.err);
            end
            total++;
            if (o_first_err_vld !== e.fvld || (e.fvld && o_first_err_idx !== 5'(e.first))) begin
                bad++;
                $display("FAIL %s first_err got=%b/%0d exp=%b/%0d", name,
                         o_first_err_vld, o_first_err_idx, e.fvld, e.first);
            end
            total++;
            if (o_pass !== e.pass) begin
                bad++;
                $display("FAIL %s pass got=%b exp=%b", name, o_pass, e.pass);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if ({o_busy, o_done, o_pass, o_first_err_vld, o_timeout, o_overrun} !== 6'b0 ||
            o_err_cnt !== 5'd0 || o_first_err_idx !== 5'd0) begin
            bad++;
            $display("FAIL %s outputs got=%b%b%b%b%b%b err=%0d idx=%0d exp=all zero", name,
                     o_busy, o_done, o_pass, o_first_err_vld, o_timeout, o_overrun,
                     o_err_cnt, o_first_err_idx);
        end
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        check_idle_outputs("reset_held");
        rst_n = 1'b1;
        cyc();
        cyc();
        check_idle_outputs("reset_released");
    endtask

    task automatic test_exact_clean();
        fill_clean();
        run_stream(1'b0, 1'b1, 0);
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL clean_k1 done/busy got=%b/%b exp=0/1", o_done, o_busy);
        end
        cyc();
        total++;
        if (o_done !== 1'b0) begin
            bad++;
            $display("FAIL clean_k2_early done got=%b exp=0", o_done);
        end
        cyc();
        total++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_pass !== 1'b1) begin
            bad++;
            $display("FAIL clean_k2 done/busy/pass got=%b/%b/%b exp=1/0/1", o_done, o_busy, o_pass);
        end
        wait_done("clean");
    endtask

    task automatic load_tol_stream();
        fill_clean();
        s_data[3] = 32'd1000; s_gold[3] = 32'd1200;
        s_data[7] = 32'd1000; s_gold[7] = 32'd1300;
        s_data[9] = 32'd0;    s_gold[9] = 32'd5;
    endtask

    task automatic test_tolerance();
        load_tol_stream();
        run_stream(1'b1, 1'b1, 0);
        wait_done("tol");
        total++;
        if (o_err_cnt !== 5'd2 || o_first_err_idx !== 5'd7 || o_pass !== 1'b0) begin
            bad++;
            $display("FAIL tol_const err/idx/pass got=%0d/%0d/%b exp=2/7/0",
                     o_err_cnt, o_first_err_idx, o_pass);
        end
    endtask

    task automatic test_exact_errors();
        load_tol_stream();
        run_stream(1'b0, 1'b1, 0);
        wait_done("exact");
        total++;
        if (o_err_cnt !== 5'd3 || o_first_err_idx !== 5'd3 || o_first_err_vld !== 1'b1) begin
            bad++;
            $display("FAIL exact_const err/idx/vld got=%0d/%0d/%b exp=3/3/1",
                     o_err_cnt, o_first_err_idx, o_first_err_vld);
        end
    endtask

    task automatic test_corners();
        fill_clean();
        s_data[2]  = 32'h8000_0000; s_gold[2]  = 32'h7FFF_FFFF;
        s_data[5]  = 32'h8000_0000; s_gold[5]  = 32'h8000_0000;
        s_data[8]  = 32'h7FFF_FFFF; s_gold[8]  = 32'h8000_0000;
        s_data[11] = 32'h8000_0000; s_gold[11] = 32'h8000_0064;
        s_data[14] = 32'd1;         s_gold[14] = 32'hFFFF_FFFF;
        run_stream(1'b1, 1'b1, 1);
        wait_done("corners");
    endtask

    task automatic test_timeout();
        fill_clean();
        i_start = 1'b1; i_mode = 1'b0;
        cyc();
        i_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1; i_data = s_data[i]; i_gold = s_gold[i];
            cyc();
        end
        i_valid = 1'b0;
        repeat (15) cyc();
        total++;
        if (o_timeout !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early to/done/busy got=%b/%b/%b exp=0/0/1",
                     o_timeout, o_done, o_busy);
        end
        cyc();
        total++;
        if (o_timeout !== 1'b1 || o_done !== 1'b1 || o_pass !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_hit to/done/pass/busy got=%b/%b/%b/%b exp=1/1/0/0",
                     o_timeout, o_done, o_pass, o_busy);
        end
    endtask

    task automatic test_gaps_overrun();
        fill_clean();
        s_gold[4]  = s_gold[4] ^ 32'd1;
        s_gold[15] = s_gold[15] + 32'd3;
        run_stream(1'b0, 1'b1, 3);
        wait_done("gaps");
        i_valid = 1'b1; i_data = $urandom; i_gold = $urandom;
        cyc();
        i_valid = 1'b0;
        total++;
        if (o_overrun !== 1'b1 || o_pass !== 1'b0 || o_err_cnt !== 5'(last_err) || o_done !== 1'b1) begin
            bad++;
            $display("FAIL overrun ovr/pass/err/done got=%b/%b/%0d/%b exp=1/0/%0d/1",
                     o_overrun, o_pass, o_err_cnt, o_done, last_err);
        end
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        total++;
        if ({o_overrun, o_timeout, o_done, o_pass, o_first_err_vld} !== 5'b0 ||
            o_err_cnt !== 5'd0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL restart_clear ovr/to/done/pass/vld=%b%b%b%b%b err=%0d busy=%b exp=00000 0 1",
                     o_overrun, o_timeout, o_done, o_pass, o_first_err_vld, o_err_cnt, o_busy);
        end
    endtask

    task automatic test_back_to_back_restart();
        fill_clean();
        s_gold[0]  = s_data[0] + 32'd1;
        s_gold[20] = s_data[20] - 32'd7;
        i_start = 1'b1; i_mode = 1'b0;
        cyc();
        i_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            i_valid = 1'b1; i_data = s_data[i]; i_gold = s_gold[i];
            cyc();
        end
        i_valid = 1'b1; i_start = 1'b1; i_data = s_data[12]; i_gold = s_gold[12] + 32'd9;
        cyc();
        i_valid = 1'b0; i_start = 1'b0;
        total++;
        if (o_err_cnt !== 5'd0 || o_first_err_vld !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL restart_mid err/vld/busy/done got=%0d/%b/%b/%b exp=0/0/1/0",
                     o_err_cnt, o_first_err_vld, o_busy, o_done);
        end
        cyc();
        total++;
        if (o_err_cnt !== 5'd0 || o_first_err_vld !== 1'b0) begin
            bad++;
            $display("FAIL restart_leak err/vld got=%0d/%b exp=0/0", o_err_cnt, o_first_err_vld);
        end
        run_stream(1'b0, 1'b0, 0);
        wait_done("restart_full");
        total++;
        if (o_err_cnt !== 5'd2 || o_first_err_idx !== 5'd0) begin
            bad++;
            $display("FAIL restart_bounds err/idx got=%0d/%0d exp=2/0", o_err_cnt, o_first_err_idx);
        end
    endtask

    task automatic test_async_reset();
        fill_clean();
        s_gold[1] = s_gold[1] + 32'd1;
        i_start = 1'b1; i_mode = 1'b0;
        cyc();
        i_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_valid = 1'b1; i_data = s_data[i]; i_gold = s_gold[i];
            cyc();
        end
        i_valid = 1'b0;
        total++;
        if (o_err_cnt !== 5'd1 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset err/busy got=%0d/%b exp=1/1", o_err_cnt, o_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        #2;
        rst_n = 1'b1;
        cyc();
        check_idle_outputs("after_reset");
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_exact_clean();
        test_tolerance();
        test_exact_errors();
        test_corners();
        test_timeout();
        test_gaps_overrun();
        test_back_to_back_restart();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
